cic_decimator: RTL and testbench
================================

# cic_decimator

Third-order CIC decimation filter that converts the 1-bit delta-sigma modulator bitstream into signed multi-bit PCM samples. It consumes a one-cycle decimation strobe from the divided-enable generator (en_8/en_16/en_32/en_64) and produces one output sample per strobe. The block also checks that strobe spacing matches the configured ratio. It sits between the modulator output and the downstream half-band/FIR stages.

## Interface
- LOG2R, default 6: log2 of the decimation ratio R; legal values 3..6, giving R = 8, 16, 32 or 64.
- W, default 3*LOG2R+2: internal and output word width; derived, never overridden.
- clk  input  1  system clock; the bitstream advances one bit per rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; all state clears while low.
- din  input  1  modulator bit; 1 maps to +1, 0 maps to -1.
- en_dec  input  1  decimation strobe, one clk wide, nominally every R clocks; tie to the en_<R> output of the enable generator.
- dout  output  W  signed two's-complement decimated sample.
- dout_valid  output  1  one-cycle pulse marking a new valid dout.
- sync_err  output  1  sticky flag for strobe-spacing fault; cleared only by reset.

## Operation
- Integrators I1, I2, I3 (W bits each) update every clk with no enable:
  - I1 <= I1 + x, where x = +1 or -1 from din.
  - I2 <= I2 + I1.
  - I3 <= I3 + I2.
  - All additions wrap modulo 2^W. No saturation is permitted, because the CIC result depends on modular wrap.
- Comb section evaluates only in an en_dec cycle, from the current I3 and delay registers D1, D2, D3 (W bits each):
  - C1 = I3 - D1; C2 = C1 - D2; C3 = C2 - D3, all modulo 2^W.
  - Same edge: D1 <= I3, D2 <= C1, D3 <= C2, dout <= C3.
  - Between strobes, dout and D1..D3 hold.
- Warm-up:
  - A 3-bit saturating counter strb_cnt increments on each strobe and saturates at 4.
  - dout_valid pulses on the edge that captures a strobe only when strb_cnt was already 4 before that strobe.
  - Result: the first 4 strobes after reset update dout but never assert dout_valid.
- Steady-state gain is R^3:
  - Constant din=1 gives dout = +2^(3*LOG2R).
  - Constant din=0 gives dout = -2^(3*LOG2R).
  - W = 3*LOG2R+2 holds these values exactly.
- Strobe-spacing check:
  - gap_cnt (LOG2R+2 bits) clears to 0 on every strobe cycle, otherwise increments and saturates at 2R.
  - On a strobe with strb_cnt >= 1, gap_cnt must equal R-1. Any other value sets sync_err.
  - gap_cnt reaching 2R also sets sync_err (strobe lost).
  - The first strobe after reset is never checked. The timeout check applies only after the first strobe.
- en_dec held high continuously counts as a strobe every cycle; for R >= 8 this sets sync_err at the second strobe.

## Timing
- Reset values: I1..I3, D1..D3, dout = 0; dout_valid = 0; sync_err = 0; strb_cnt = 0; gap_cnt = 0.
- Latency: dout and dout_valid update on the rising edge that samples en_dec=1, so they are visible the cycle after the strobe.
- dout_valid is exactly one cycle wide and is never high in two consecutive cycles when spacing is legal.
- din contributes to I3 three edges after it is sampled. This pipeline offset is part of the response and is covered by the 4-strobe warm-up.
- sync_err asserts on the edge that detects the fault and stays high until rst_n falls. Filtering continues unaffected while it is high.
- Reset mid-operation clears everything immediately and asynchronously; the warm-up restarts from zero strobes.
- Reset release needs no alignment to en_dec. The first strobe may arrive at any phase.

## Test plan
- R=8, din=1 constant, en_dec every 8 clk -> dout_valid first pulses after the 5th strobe, with dout=+512; every later pulse gives +512; sync_err=0.
- R=8, din=0 constant -> dout=-512 (11-bit 0x600) on every valid pulse.
- R=8, din alternating 1,0 -> steady-state dout=0 on every valid pulse.
- R=64, din=1 constant -> dout=+262144 (W=20); wrap inside the integrators must not corrupt the result.
- R=8, strobes at spacing 8, 8, 9 -> sync_err rises on the edge of the late strobe and stays high. In a separate run, stop strobes after the 3rd -> sync_err rises 16 clk after the last strobe.
- Run steady state, pulse rst_n low for 2 cycles mid-stream -> all outputs return to 0 at once; after release, 4 strobes produce no dout_valid and the 5th restores the correct value.

Source files
------------

// File: rtl/cic_decimator_if.sv
// cic_if: bitstream/strobe inputs and PCM outputs of the CIC decimator.
interface cic_if #(parameter int W = 20);
  logic         din;
  logic         en_dec;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         sync_err;
  modport master (output din, en_dec, input dout, dout_valid, sync_err);
  modport slave  (input din, en_dec, output dout, dout_valid, sync_err);
endinterface

// File: rtl/cic_decimator.sv
// cic_decimator: third-order CIC decimator, 1-bit bitstream to signed PCM, with strobe-spacing check.
module cic_decimator #(
  parameter  int LOG2R = 6,
  localparam int W     = 3*LOG2R+2
)(
  input logic  clk,
  input logic  rst_n,
  cic_if.slave bus
);
  localparam int GW = LOG2R+2;
  localparam logic [GW-1:0] R_M1     = GW'((1 << LOG2R) - 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(2 << LOG2R);
  localparam logic [GW-1:0] GAP_LAST = GW'((2 << LOG2R) - 1);
  logic          en;
  logic [W-1:0]  x, c1, c2, c3;
  logic [W-1:0]  i1_q, i2_q, i3_q, d1_q, d2_q, d3_q, dout_q;
  logic [W-1:0]  i1_d, i2_d, i3_d, d1_d, d2_d, d3_d, dout_d;
  logic [2:0]    strb_q, strb_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          vld_q, vld_d, err_q, err_d;
  assign en = bus.en_dec;
  // integrators and combs wrap modulo 2^W; the wrap cancels in the comb differences
  always_comb begin
    x      = bus.din ? W'(1) : '1;
    i1_d   = i1_q + x;
    i2_d   = i2_q + i1_q;
    i3_d   = i3_q + i2_q;
    c1     = i3_q - d1_q;
    c2     = c1 - d2_q;
    c3     = c2 - d3_q;
    d1_d   = en ? i3_q : d1_q;
    d2_d   = en ? c1 : d2_q;
    d3_d   = en ? c2 : d3_q;
    dout_d = en ? c3 : dout_q;
    strb_d = (en && strb_q != 3'd4) ? strb_q + 3'd1 : strb_q;
    vld_d  = en && strb_q == 3'd4;
    gap_d  = en ? '0 : (gap_q == GAP_MAX ? gap_q : gap_q + GW'(1));
    // checks arm after the first strobe; timeout fires on the edge gap reaches 2R
    err_d  = err_q | ((strb_q != 3'd0) && (en ? gap_q != R_M1 : gap_q == GAP_LAST));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1_q   <= '0;
      i2_q   <= '0;
      i3_q   <= '0;
      d1_q   <= '0;
      d2_q   <= '0;
      d3_q   <= '0;
      dout_q <= '0;
      strb_q <= '0;
      gap_q  <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      i1_q   <= i1_d;
      i2_q   <= i2_d;
      i3_q   <= i3_d;
      d1_q   <= d1_d;
      d2_q   <= d2_d;
      d3_q   <= d3_d;
      dout_q <= dout_d;
      strb_q <= strb_d;
      gap_q  <= gap_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
    end
  end
  assign bus.dout       = dout_q;
  assign bus.dout_valid = vld_q;
  assign bus.sync_err   = err_q;
endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator: directed checks of gain, warm-up, strobe-spacing faults and reset for R=8 and R=64.
module tb_cic_decimator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   d = 1'b0;
  int   checks = 0;
  int   errors = 0;
  cic_if #(.W(11)) bus8 ();
  cic_if #(.W(20)) bus64 ();
  cic_decimator #(.LOG2R(3)) u8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  cic_decimator #(.LOG2R(6)) u64 (.clk(clk), .rst_n(rst_n), .bus(bus64));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, act, exp);
    end
  endtask
  task automatic step(input logic di, input logic e8, input logic e64);
    bus8.din = di;
    bus64.din = di;
    bus8.en_dec = e8;
    bus64.en_dec = e64;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic run(input int r, input int n, input bit alt, input int exp);
    logic e;
    logic vld, se;
    logic signed [31:0] dv;
    for (int s = 1; s <= n; s++) begin
      for (int c = 0; c < r; c++) begin
        e = (c == r - 1);
        d = alt ? ~d : (exp > 0);
        step(d, r == 8 ? e : 1'b0, r == 64 ? e : 1'b0);
        vld = (r == 8) ? bus8.dout_valid : bus64.dout_valid;
        dv  = (r == 8) ? 32'($signed(bus8.dout)) : 32'($signed(bus64.dout));
        se  = (r == 8) ? bus8.sync_err : bus64.sync_err;
        chk("vld", vld, e && s > 4);
        if (e && s > 4) chk("dout", dv, exp);
      end
    end
    chk("sync_ok", se, 0);
  endtask
  task automatic strobe8(input int spacing);
    repeat (spacing - 1) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
  endtask
  initial begin
    bus8.din = 1'b0;
    bus8.en_dec = 1'b0;
    bus64.din = 1'b0;
    bus64.en_dec = 1'b0;
    do_reset();
    chk("rst_dout8", bus8.dout, 0);
    chk("rst_vld8", bus8.dout_valid, 0);
    chk("rst_err8", bus8.sync_err, 0);
    chk("rst_dout64", bus64.dout, 0);
    chk("rst_vld64", bus64.dout_valid, 0);
    chk("rst_err64", bus64.sync_err, 0);
    run(8, 7, 1'b0, 512);
    do_reset();
    run(8, 6, 1'b0, -512);
    chk("neg_hex", bus8.dout, 'h600);
    do_reset();
    run(8, 7, 1'b1, 0);
    do_reset();
    run(64, 6, 1'b0, 262144);
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    strobe8(8);
    strobe8(8);
    chk("late_pre", bus8.sync_err, 0);
    repeat (8) step(1'b0, 1'b0, 1'b0);
    chk("late_wait", bus8.sync_err, 0);
    step(1'b0, 1'b1, 1'b0);
    chk("late_edge", bus8.sync_err, 1);
    strobe8(8);
    chk("late_sticky", bus8.sync_err, 1);
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    strobe8(8);
    strobe8(8);
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("tmo_%0d", k), bus8.sync_err, k >= 16);
    end
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    chk("cont_1", bus8.sync_err, 0);
    step(1'b0, 1'b1, 1'b0);
    chk("cont_2", bus8.sync_err, 1);
    do_reset();
    run(8, 6, 1'b0, 512);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_dout", bus8.dout, 0);
    chk("mid_vld", bus8.dout_valid, 0);
    chk("mid_err", bus8.sync_err, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(8, 6, 1'b0, 512);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
